df_load: RTL and testbench
==========================

# df_load

Write-side frame loader for the neuron datapath: accepts a word stream over a valid/ready handshake and writes each word into the 8-entry neuron RAM at addresses 0..7. When all eight words are stored it raises `frame_rdy`, which drives the read-side counter's `in_rdy`. It holds the frame until the consumer releases it, then refills. Together with the read-side address counter it forms one RAM ping between producer and neuron.

## Interface
Parameters:
- `DW`, 16, data word width.
- `TO_CYC`, 64, idle-gap limit in cycles for partial-frame abort; used only with `DF_LOAD_TIMEOUT_EN`; legal range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  DW  incoming word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a word; registered.
- `wr_en`  out  1  RAM write strobe; registered.
- `wr_addr`  out  3  RAM write address (`WordAddrBus`); registered.
- `wr_data`  out  DW  RAM write data; registered.
- `frame_rdy`  out  1  all eight words stored; connects to the reader's `in_rdy`.
- `frame_done`  in  1  one-cycle pulse from the consumer releasing the frame.
- `err_abort`  out  1  one-cycle pulse when a partial frame is dropped.

## Operation
- Internal state:
  - FSM states FILL, LAST, FULL.
  - 3-bit write counter `cnt`.
  - With the macro only, an idle counter of 8 bits.
- Reset values:
  - FSM in FILL, `cnt` = 0.
  - `in_ready` = 1.
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `frame_rdy` = 0, `err_abort` = 0.
- A word is accepted when `in_valid & in_ready`.
- FILL:
  - On accept: `wr_en`=1, `wr_addr`=`cnt`, `wr_data`=`in_data` on the next cycle; `cnt` increments.
  - No accept: `wr_en`=0 next cycle; `wr_addr` and `wr_data` hold their values.
  - An accept with `cnt`=7 moves the FSM to LAST, and `in_ready` goes to 0 on the same edge.
- LAST: lasts exactly one cycle while the write to address 7 completes. `cnt` wraps to 0. Next state is FULL with `frame_rdy`=1.
- FULL:
  - `in_ready`=0 and `frame_rdy`=1; `wr_en` stays 0.
  - On `frame_done`: next cycle `frame_rdy`=0, `in_ready`=1, FSM returns to FILL with `cnt`=0.
- `frame_done` in FILL or LAST is ignored.
- `in_valid` while `in_ready`=0 is ignored; the source must hold the word.
- Asserting reset mid-frame drops the partial frame. All outputs return to their reset values asynchronously.

## Timing
- Accept at cycle N: the write appears at N+1.
- 8th accept at N:
  - `in_ready`=0 at N+1.
  - Write to address 7 at N+1.
  - `frame_rdy`=1 at N+2.
- `frame_done` at M: `frame_rdy`=0 and `in_ready`=1 at M+1. The earliest next accept is M+1.
- Best-case frame period: 8 accepts, then 1 LAST cycle, then at least 1 FULL cycle, then release.
- Back-to-back accepts are sustained at one word per cycle in FILL.

## Configuration
- Macro `DF_LOAD_TIMEOUT_EN`.
- Defined:
  - In FILL with `cnt`>0, count consecutive cycles without an accept; any accept clears the count.
  - When the count reaches `TO_CYC`: `cnt` returns to 0, `err_abort` pulses for one cycle on the next edge, and the FSM stays in FILL.
  - RAM contents are not cleared.
  - The idle counter is held at 0 in LAST and FULL, and while `cnt`=0.
- Undefined: `err_abort` is tied to 0, no idle counter is built, and a partial frame waits indefinitely.

## Test plan
- Reset, then stream 0x0011..0x0088 back-to-back from cycle 1 -> `wr_addr` 0..7 on cycles 2..9 carrying those values, `in_ready`=0 from cycle 9, `frame_rdy`=1 at cycle 10.
- Hold FULL for 20 cycles with `in_valid`=1 -> no `wr_en`, `in_ready` stays 0; pulse `frame_done` -> `frame_rdy`=0 and `in_ready`=1 next cycle, next word written to address 0.
- Gapped stream with `in_valid` toggling 1/0 -> addresses strictly 0..7 with no duplicates, `wr_en` high only on cycles following an accept.
- Pulse `frame_done` during FILL at `cnt`=3 -> no effect; the frame completes normally after 5 more words.
- Assert reset after 5 words, release, stream 8 words -> writes start at address 0, `frame_rdy` after the 8th.
- With `DF_LOAD_TIMEOUT_EN`, `TO_CYC`=4: send 3 words then idle -> single-cycle `err_abort` after 4 idle cycles, and the next word is written to address 0. Without the macro, the same stimulus -> `err_abort` stays 0 and the next word goes to address 3.

Source files
------------

// File: rtl/df_load.sv
// Write-side frame loader: stores an 8-word frame into the neuron RAM and holds it until released.
// Optional partial-frame idle abort is built only when DF_LOAD_TIMEOUT_EN is defined.
module df_load #(
    parameter int DW     = 16,
    parameter int TO_CYC = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [2:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          frame_rdy,
    input  logic          frame_done,
    output logic          err_abort
);

    typedef enum logic [1:0] {FILL, LAST, FULL} state_t;

    if (TO_CYC < 1 || TO_CYC > 255) begin : g_bad_to_cyc
        $error("df_load: TO_CYC must be in 1..255");
    end

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic          in_ready_nxt, wr_en_nxt, frame_rdy_nxt, err_abort_nxt;
    logic [2:0]    wr_addr_nxt;
    logic [DW-1:0] wr_data_nxt;
    logic          accept;

`ifdef DF_LOAD_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TO_CYC - 1);
    logic [7:0] idle_cnt, idle_nxt;
`endif

    assign accept = in_valid & in_ready;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        in_ready_nxt  = in_ready;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        frame_rdy_nxt = frame_rdy;
        err_abort_nxt = 1'b0;
`ifdef DF_LOAD_TIMEOUT_EN
        idle_nxt      = 8'd0;
`endif
        case (state)
            FILL: begin
                if (accept) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = cnt;
                    wr_data_nxt = in_data;
                    cnt_nxt     = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state_nxt    = LAST;
                        in_ready_nxt = 1'b0;
                    end
                end
`ifdef DF_LOAD_TIMEOUT_EN
                // The abort fires on the edge that closes the TO_CYC-th idle cycle.
                else if (cnt != 3'd0) begin
                    if (idle_cnt == IDLE_LAST) begin
                        cnt_nxt       = 3'd0;
                        err_abort_nxt = 1'b1;
                    end else begin
                        idle_nxt = idle_cnt + 8'd1;
                    end
                end
`endif
            end
            LAST: begin
                state_nxt     = FULL;
                cnt_nxt       = 3'd0;
                frame_rdy_nxt = 1'b1;
            end
            FULL: begin
                if (frame_done) begin
                    state_nxt     = FILL;
                    cnt_nxt       = 3'd0;
                    frame_rdy_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            cnt       <= 3'd0;
            in_ready  <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= 3'd0;
            wr_data   <= '0;
            frame_rdy <= 1'b0;
            err_abort <= 1'b0;
`ifdef DF_LOAD_TIMEOUT_EN
            idle_cnt  <= 8'd0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            frame_rdy <= frame_rdy_nxt;
            err_abort <= err_abort_nxt;
`ifdef DF_LOAD_TIMEOUT_EN
            idle_cnt  <= idle_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_df_load.sv
// Bench for df_load: frame-level model checked every cycle plus literal expectations per scenario.
// Build with DF_LOAD_TIMEOUT_EN defined to exercise the idle abort (TO_CYC is 4 here).
module tb_df_load;

    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_rdy;
    logic          frame_done = 1'b0;
    logic          err_abort;

    int checks = 0;
    int errors = 0;

    df_load #(.DW(DW), .TO_CYC(TO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_rdy(frame_rdy), .frame_done(frame_done), .err_abort(err_abort)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are set now, held across the next rising edge, and the task returns 1 ns after it.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic done);
        in_valid   = v;
        in_data    = d;
        frame_done = done;
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: words held in the current frame, release handshake, idle gap.
    int            m_words;
    int            m_idle;
    logic          m_acc;
    logic          exp_in_ready, exp_wr_en, exp_frame_rdy, exp_err_abort;
    logic [2:0]    exp_addr;
    logic [DW-1:0] exp_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_words = 0; m_idle = 0;
            exp_in_ready = 1'b1; exp_wr_en = 1'b0; exp_addr = 3'd0; exp_data = '0;
            exp_frame_rdy = 1'b0; exp_err_abort = 1'b0;
        end else begin
            m_acc = in_valid && (m_words < 8);
            exp_wr_en = m_acc;
            exp_err_abort = 1'b0;
            if (m_acc) begin
                exp_addr = 3'(m_words);
                exp_data = in_data;
                m_words++;
                m_idle = 0;
            end else if (m_words == 8) begin
                if (exp_frame_rdy && frame_done) begin
                    m_words = 0;
                    exp_frame_rdy = 1'b0;
                end else begin
                    exp_frame_rdy = 1'b1;
                end
            end
`ifdef DF_LOAD_TIMEOUT_EN
            else if (m_words > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_words = 0;
                    m_idle = 0;
                    exp_err_abort = 1'b1;
                end
            end
`endif
            exp_in_ready = (m_words < 8);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("m_in_ready", 32'(in_ready), 32'(exp_in_ready));
            checkOutput("m_wr_en", 32'(wr_en), 32'(exp_wr_en));
            checkOutput("m_wr_addr", 32'(wr_addr), 32'(exp_addr));
            checkOutput("m_wr_data", 32'(wr_data), 32'(exp_data));
            checkOutput("m_frame_rdy", 32'(frame_rdy), 32'(exp_frame_rdy));
            checkOutput("m_err_abort", 32'(err_abort), 32'(exp_err_abort));
        end
    end

    initial begin
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_frame_rdy", 32'(frame_rdy), 32'd0);
        checkOutput("rst_err_abort", 32'(err_abort), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Back-to-back frame 0x0011..0x0088
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'((i + 1) * 17), 1'b0);
            checkOutput("b2b_wr_en", 32'(wr_en), 32'd1);
            checkOutput("b2b_wr_addr", 32'(wr_addr), 32'(i));
            checkOutput("b2b_wr_data", 32'(wr_data), 32'((i + 1) * 17));
        end
        checkOutput("last_in_ready", 32'(in_ready), 32'd0);
        checkOutput("last_frame_rdy", 32'(frame_rdy), 32'd0);
        applyStimulus(1'b1, 16'h0099, 1'b0);
        checkOutput("full_frame_rdy", 32'(frame_rdy), 32'd1);
        checkOutput("full_wr_en", 32'(wr_en), 32'd0);

        // Hold FULL with valid asserted, then release
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 16'h0099, 1'b0);
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        checkOutput("hold_wr_addr", 32'(wr_addr), 32'd7);
        applyStimulus(1'b1, 16'h0099, 1'b1);
        checkOutput("rel_frame_rdy", 32'(frame_rdy), 32'd0);
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 16'h00A1, 1'b0);
        checkOutput("rel_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rel_wr_data", 32'(wr_data), 32'h00A1);

        // Gapped stream completes the frame (words 1..7)
        for (int k = 0; k < 14; k++) begin
            applyStimulus(k % 2 == 0, 16'(16'h00B0 + k), 1'b0);
            checkOutput("gap_wr_en", 32'(wr_en), 32'(k % 2 == 0));
        end
        checkOutput("gap_last_addr", 32'(wr_addr), 32'd7);
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("gap_rel_in_ready", 32'(in_ready), 32'd1);

        // frame_done during FILL at cnt=3 is ignored
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(16'h0C00 + i), 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("fd_fill_in_ready", 32'(in_ready), 32'd1);
        checkOutput("fd_fill_frame_rdy", 32'(frame_rdy), 32'd0);
        for (int i = 3; i < 8; i++) applyStimulus(1'b1, 16'(16'h0C00 + i), 1'b0);
        checkOutput("fd_fill_addr7", 32'(wr_addr), 32'd7);
        checkOutput("fd_fill_data7", 32'(wr_data), 32'h0C07);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("fd_fill_frame_rdy2", 32'(frame_rdy), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1);

        // Reset after 5 words drops the partial frame
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h0D00 + i), 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("arst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("arst_wr_data", 32'(wr_data), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'(16'h0E00 + i), 1'b0);
            if (i == 0) checkOutput("arst_first_addr", 32'(wr_addr), 32'd0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("arst_frame_rdy", 32'(frame_rdy), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1);

        // Three words then idle
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(16'h0F00 + i), 1'b0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
`ifdef DF_LOAD_TIMEOUT_EN
            checkOutput("to_err_abort", 32'(err_abort), 32'(k == TO));
`else
            checkOutput("to_err_abort", 32'(err_abort), 32'd0);
`endif
        end
        applyStimulus(1'b1, 16'h0F77, 1'b0);
`ifdef DF_LOAD_TIMEOUT_EN
        checkOutput("to_next_addr", 32'(wr_addr), 32'd0);
`else
        checkOutput("to_next_addr", 32'(wr_addr), 32'd3);
`endif
        checkOutput("to_next_data", 32'(wr_data), 32'h0F77);
        applyStimulus(1'b0, 16'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
